// File: rtl/bsg_counter_up_down_sat.sv
// bsg_counter_up_down_sat
//
// Up/down counter with multi-unit steps per cycle, a configurable maximum,
// load and clear, and sticky overflow/underflow flags. Results outside
// [0, max_val_p] saturate to the nearest end. When
// BSG_COUNTER_UP_DOWN_SAT_WRAP_EN is defined they wrap modulo
// (max_val_p+1) instead. Out-of-range loads follow the same rule.
//
// Ports:
//   clk_i          clock
//   reset_n_i      synchronous active-low reset
//   clear_i        count -> 0 next cycle (error flags untouched)
//   load_v_i       count -> load_val_i next cycle
//   load_val_i     value to load (width_lp bits)
//   up_i, down_i   increment / decrement amounts (step_w_lp bits each)
//   err_clr_i      clear both sticky error flags
//   count_o        registered count
//   zero_o         registered, count_o == 0
//   full_o         registered, count_o == max_val_p
//   almost_full_o  registered, count_o >= almost_full_p
//   overflow_o     sticky, a result exceeded max_val_p
//   underflow_o    sticky, a result went below 0
//
// Priority, highest first: reset, clear, load, up/down.
// All outputs come straight from registers.

module bsg_counter_up_down_sat #(
  parameter int max_val_p     = 1023,
  parameter int init_val_p    = 0,
  parameter int max_step_p    = 1,
  parameter int almost_full_p = max_val_p - 1,
  localparam int width_lp     = $clog2(max_val_p + 1),
  localparam int step_w_lp    = (max_step_p > 0) ? $clog2(max_step_p + 1) : 1
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                clear_i,
  input  logic                load_v_i,
  input  logic [width_lp-1:0] load_val_i,
  input  logic [step_w_lp-1:0] up_i,
  input  logic [step_w_lp-1:0] down_i,
  input  logic                err_clr_i,
  output logic [width_lp-1:0] count_o,
  output logic                zero_o,
  output logic                full_o,
  output logic                almost_full_o,
  output logic                overflow_o,
  output logic                underflow_o
);

  // Two extra bits: one for the carry of count+up, one for the sign.
  localparam int sum_w_lp = width_lp + 2;
  localparam logic signed [sum_w_lp-1:0] max_s_lp = sum_w_lp'(max_val_p);
  localparam logic signed [sum_w_lp-1:0] mod_s_lp = sum_w_lp'(max_val_p + 1);
  localparam logic [width_lp:0]          max_u_lp = (width_lp + 1)'(max_val_p);
  localparam logic [width_lp-1:0]        af_lp    = width_lp'(almost_full_p);
  localparam logic [width_lp-1:0]        init_lp  = width_lp'(init_val_p);

  logic [width_lp-1:0]        count_q, count_d;
  logic                       zero_q, full_q, af_q;
  logic                       ovf_q, ovf_d;
  logic                       unf_q, unf_d;
  logic signed [sum_w_lp-1:0] sum_s;
  logic                       ovf_evt, unf_evt;

  always_comb begin
    count_d = count_q;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    sum_s   = $signed({2'b00, count_q})
            + $signed(sum_w_lp'(up_i))
            - $signed(sum_w_lp'(down_i));

    if (clear_i) begin
      count_d = '0;
    end else if (load_v_i) begin
      // Unsigned compare with one extra bit so max_val_p = 2^n-1 works too.
      if ({1'b0, load_val_i} > max_u_lp) begin
        ovf_evt = 1'b1;
`ifdef BSG_COUNTER_UP_DOWN_SAT_WRAP_EN
        // load_val_i < 2^width_lp <= 2*(max_val_p+1): one subtraction suffices.
        count_d = width_lp'({1'b0, load_val_i} - (width_lp + 1)'(max_val_p + 1));
`else
        count_d = width_lp'(max_val_p);
`endif
      end else begin
        count_d = load_val_i;
      end
    end else if (sum_s > max_s_lp) begin
      ovf_evt = 1'b1;
`ifdef BSG_COUNTER_UP_DOWN_SAT_WRAP_EN
      count_d = width_lp'(sum_s - mod_s_lp);
`else
      count_d = width_lp'(max_val_p);
`endif
    end else if (sum_s < 0) begin
      unf_evt = 1'b1;
`ifdef BSG_COUNTER_UP_DOWN_SAT_WRAP_EN
      count_d = width_lp'(sum_s + mod_s_lp);
`else
      count_d = '0;
`endif
    end else begin
      count_d = width_lp'(sum_s);
    end

    // A new event in the same cycle as err_clr_i keeps the flag set.
    ovf_d = ovf_evt | (ovf_q & ~err_clr_i);
    unf_d = unf_evt | (unf_q & ~err_clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_q <= init_lp;
      zero_q  <= (init_lp == '0);
      full_q  <= (init_val_p == max_val_p);
      af_q    <= (init_lp >= af_lp);
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      // Status flags come from count_d so they line up with count_o.
      zero_q  <= (count_d == '0);
      full_q  <= ({1'b0, count_d} == max_u_lp);
      af_q    <= (count_d >= af_lp);
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count_o       = count_q;
  assign zero_o        = zero_q;
  assign full_o        = full_q;
  assign almost_full_o = af_q;
  assign overflow_o    = ovf_q;
  assign underflow_o   = unf_q;

endmodule

// File: tb/tb_bsg_counter_up_down_sat.sv
// Testbench for bsg_counter_up_down_sat.
// dut_a: max_val_p=1023, init_val_p=5, max_step_p=1 (reset behaviour).
// dut_b: max_val_p=10, init_val_p=0, max_step_p=4, almost_full_p=9.
// Directed vectors with hand-computed expectations. Wrap-mode expectations
// are selected with BSG_COUNTER_UP_DOWN_SAT_WRAP_EN.

module tb_bsg_counter_up_down_sat;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- dut_a ----------------
  logic       a_rst_n = 1'b0;
  logic       a_up    = 1'b0;
  logic [9:0] a_count;
  logic       a_zero, a_full, a_af, a_ovf, a_unf;

  bsg_counter_up_down_sat #(
    .max_val_p(1023), .init_val_p(5), .max_step_p(1)
  ) dut_a (
    .clk_i(clk), .reset_n_i(a_rst_n), .clear_i(1'b0), .load_v_i(1'b0),
    .load_val_i(10'd0), .up_i(a_up), .down_i(1'b0), .err_clr_i(1'b0),
    .count_o(a_count), .zero_o(a_zero), .full_o(a_full),
    .almost_full_o(a_af), .overflow_o(a_ovf), .underflow_o(a_unf)
  );

  // ---------------- dut_b ----------------
  logic       b_rst_n = 1'b0;
  logic       b_clr   = 1'b0;
  logic       b_lv    = 1'b0;
  logic [3:0] b_lval  = '0;
  logic [2:0] b_up    = '0;
  logic [2:0] b_dn    = '0;
  logic       b_ec    = 1'b0;
  logic [3:0] b_count;
  logic       b_zero, b_full, b_af, b_ovf, b_unf;

  bsg_counter_up_down_sat #(
    .max_val_p(10), .init_val_p(0), .max_step_p(4), .almost_full_p(9)
  ) dut_b (
    .clk_i(clk), .reset_n_i(b_rst_n), .clear_i(b_clr), .load_v_i(b_lv),
    .load_val_i(b_lval), .up_i(b_up), .down_i(b_dn), .err_clr_i(b_ec),
    .count_o(b_count), .zero_o(b_zero), .full_o(b_full),
    .almost_full_o(b_af), .overflow_o(b_ovf), .underflow_o(b_unf)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full status check of dut_b: count, zero, full, almost_full, ovf, unf.
  task automatic check_b(input string tag, input int cnt, input int z,
                         input int f, input int af, input int o, input int u);
    check({tag, ".count"}, int'(b_count), cnt);
    check({tag, ".zero"},  int'(b_zero),  z);
    check({tag, ".full"},  int'(b_full),  f);
    check({tag, ".af"},    int'(b_af),    af);
    check({tag, ".ovf"},   int'(b_ovf),   o);
    check({tag, ".unf"},   int'(b_unf),   u);
  endtask

  // ---------------- drivers ----------------
  // Apply one cycle of inputs to dut_b, then return inputs to idle and
  // leave the bench 1 time unit after the edge for sampling.
  task automatic drive_b(input logic clr, input logic lv, input int lval,
                         input int up, input int dn, input logic ec);
    b_clr  = clr;
    b_lv   = lv;
    b_lval = 4'(lval);
    b_up   = 3'(up);
    b_dn   = 3'(dn);
    b_ec   = ec;
    @(posedge clk);
    #1;
    b_clr = 1'b0; b_lv = 1'b0; b_lval = '0;
    b_up  = '0;   b_dn = '0;   b_ec  = 1'b0;
  endtask

  task automatic load_b(input int v);
    drive_b(1'b0, 1'b1, v, 0, 0, 1'b0);
  endtask

  task automatic step_b(input int up, input int dn, input logic ec);
    drive_b(1'b0, 1'b0, 0, up, dn, ec);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // dut_a: reset held 2 cycles while up_i=1
    a_up = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("a_rst.count", int'(a_count), 5);
    check("a_rst.ovf",   int'(a_ovf),   0);
    check("a_rst.unf",   int'(a_unf),   0);
    check("a_rst.zero",  int'(a_zero),  0);
    check("a_rst.full",  int'(a_full),  0);
    a_rst_n = 1'b1;
    @(posedge clk);
    #1;
    a_up = 1'b0;
    check("a_up1.count", int'(a_count), 6);
    @(posedge clk);
    #1;
    check("a_idle.count", int'(a_count), 6);
    check("a_idle.af",    int'(a_af),    0);

    // dut_b: reset state
    b_rst_n = 1'b1;
    b_rst_n = 1'b0;
    @(posedge clk);
    #1;
    b_rst_n = 1'b1;
    check_b("b_rst", 0, 1, 0, 0, 0, 0);

`ifndef BSG_COUNTER_UP_DOWN_SAT_WRAP_EN
    // saturate high
    load_b(8);            check_b("b_ld8",  8, 0, 0, 0, 0, 0);
    step_b(4, 0, 1'b0);   check_b("b_sat",  10, 0, 1, 1, 1, 0);
    step_b(0, 0, 1'b1);   check_b("b_eclr", 10, 0, 1, 1, 0, 0);
    // err_clr together with a new overflow: new event wins
    step_b(1, 0, 1'b1);   check_b("b_ecol", 10, 0, 1, 1, 1, 0);
    step_b(0, 0, 1'b1);   check_b("b_ecl2", 10, 0, 1, 1, 0, 0);
    // landing exactly on max is legal
    load_b(6);            check_b("b_ld6",  6, 0, 0, 0, 0, 0);
    step_b(4, 0, 1'b0);   check_b("b_exmx", 10, 0, 1, 1, 0, 0);
    // underflow and netting
    load_b(2);            check_b("b_ld2",  2, 0, 0, 0, 0, 0);
    step_b(0, 3, 1'b0);   check_b("b_unf",  0, 1, 0, 0, 0, 1);
    step_b(2, 2, 1'b0);   check_b("b_net0", 0, 1, 0, 0, 0, 1);
    // priority: clear beats load and up; clear keeps flags
    drive_b(1'b1, 1'b1, 7, 1, 0, 1'b0);
    check_b("b_clr",  0, 1, 0, 0, 0, 1);
    load_b(7);            check_b("b_ld7",  7, 0, 0, 0, 0, 1);
    // load beats up/down
    drive_b(1'b0, 1'b1, 3, 4, 0, 1'b0);
    check_b("b_ldpr", 3, 0, 0, 0, 0, 1);
    step_b(3, 3, 1'b0);   check_b("b_net3", 3, 0, 0, 0, 0, 1);
    step_b(4, 1, 1'b0);   check_b("b_mix",  6, 0, 0, 0, 0, 1);
    // out-of-range load
    load_b(15);           check_b("b_ld15", 10, 0, 1, 1, 1, 1);
    step_b(0, 0, 1'b1);   check_b("b_ecb",  10, 0, 1, 1, 0, 0);
    // almost full threshold
    load_b(8);            check_b("b_af8",  8, 0, 0, 0, 0, 0);
    step_b(1, 0, 1'b0);   check_b("b_af9",  9, 0, 0, 1, 0, 0);
    step_b(0, 1, 1'b0);   check_b("b_af8b", 8, 0, 0, 0, 0, 0);
    // landing exactly on 0 is legal
    step_b(0, 4, 1'b0);   check_b("b_dn4",  4, 0, 0, 0, 0, 0);
    step_b(0, 4, 1'b0);   check_b("b_ex0",  0, 1, 0, 0, 0, 0);
`else
    // wrap high: 9 + 4 = 13 -> 2
    load_b(9);            check_b("b_ld9",  9, 0, 0, 1, 0, 0);
    step_b(4, 0, 1'b0);   check_b("b_wrph", 2, 0, 0, 0, 1, 0);
    step_b(0, 0, 1'b1);   check_b("b_eclr", 2, 0, 0, 0, 0, 0);
    // wrap low: 1 - 3 = -2 -> 9
    load_b(1);            check_b("b_ld1",  1, 0, 0, 0, 0, 0);
    step_b(0, 3, 1'b0);   check_b("b_wrpl", 9, 0, 0, 1, 0, 1);
    // 9 + 2 = 11 -> 0
    step_b(2, 0, 1'b0);   check_b("b_wrp0", 0, 1, 0, 0, 1, 1);
    // landing exactly on max is legal
    load_b(6);            check_b("b_ld6",  6, 0, 0, 0, 1, 1);
    step_b(0, 0, 1'b1);   check_b("b_ecb",  6, 0, 0, 0, 0, 0);
    step_b(4, 0, 1'b0);   check_b("b_exmx", 10, 0, 1, 1, 0, 0);
    step_b(3, 3, 1'b0);   check_b("b_net3", 10, 0, 1, 1, 0, 0);
    // priority: clear beats load and up
    drive_b(1'b1, 1'b1, 7, 1, 0, 1'b0);
    check_b("b_clr",  0, 1, 0, 0, 0, 0);
    load_b(7);            check_b("b_ld7",  7, 0, 0, 0, 0, 0);
    // out-of-range load: 15 mod 11 = 4
    load_b(15);           check_b("b_ld15", 4, 0, 0, 0, 1, 0);
    load_b(8);            check_b("b_af8",  8, 0, 0, 0, 1, 0);
    step_b(1, 0, 1'b0);   check_b("b_af9",  9, 0, 0, 1, 1, 0);
`endif

    // reset mid-operation with flags set and up_i active
    load_b(5);
    step_b(0, 4, 1'b0);
    step_b(0, 4, 1'b0);   // 5-4=1, 1-4 -> underflow either mode
    check("b_pre.unf", int'(b_unf), 1);
    b_rst_n = 1'b0;
    step_b(4, 0, 1'b0);
    b_rst_n = 1'b1;
    check_b("b_mrst", 0, 1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
